// File: rtl/pwm_duty_capture.sv
// PWM duty-cycle receiver: recovers the DATA_W-bit value encoded as high time in a 2^DATA_W period.
// Define PWM_CAP_STICKY_ERR_EN to make err a level that holds until rst or en low.
module pwm_duty_capture #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 2 * (2 ** DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm_in,
  output logic [DATA_W-1:0] value,
  output logic              valid,
  output logic              err,
  output logic              idle
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] PERIOD = CW'(2 ** DATA_W);
  localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_q;
  logic [CW-1:0]          per_q, per_d, hi_q, hi_d;
  logic [DATA_W-1:0]      value_q, value_d;
  logic                   valid_q, valid_d, err_q, err_d, idle_q, idle_d;
  logic                   err_ev;
  logic                   s, rise;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p_q;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    hi_d    = hi_q;
    value_d = value_q;
    valid_d = 1'b0;
    err_ev  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise && en) begin
          state_d = StMeasure;
          per_d   = ONE;
          hi_d    = ONE;
        end
      end
      StMeasure: begin
        if (!en) begin
          // en dominates a coincident rise: drop to idle silently
          state_d = StIdle;
        end else if (rise) begin
          per_d = ONE;
          hi_d  = ONE;
          if (per_q == PERIOD && hi_q < PERIOD) begin
            value_d = hi_q[DATA_W-1:0];
            valid_d = 1'b1;
          end else begin
            err_ev = 1'b1;
          end
        end else if (per_q == TMO) begin
          if (s) begin
            err_ev = 1'b1;
          end else begin
            value_d = '0;
            valid_d = 1'b1;
          end
          state_d = StIdle;
        end else begin
          // per_q is below TMO on this path, so the increment cannot pass saturation
          per_d = per_q + ONE;
          if (s && hi_q != TMO) hi_d = hi_q + ONE;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef PWM_CAP_STICKY_ERR_EN
    err_d = en ? (err_q | err_ev) : 1'b0;
`else
    err_d = err_ev;
`endif
    idle_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sync_q  <= '0;
      p_q     <= 1'b0;
      per_q   <= '0;
      hi_q    <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      p_q     <= s;
      per_q   <= per_d;
      hi_q    <= hi_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
    end
  end

  assign value = value_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign idle  = idle_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: directed phases plus random periods, checked every cycle
// against a timestamp-based model of the synchronized waveform.
module tb_pwm_duty_capture;

  localparam int DW   = 4;
  localparam int SYNC = 2;
  localparam int TMO  = 32;
  localparam int NOM  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          pwm_in = 1'b0;
  logic [DW-1:0] value;
  logic          valid, err, idle;

  pwm_duty_capture #(
    .DATA_W     (DW),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .pwm_in(pwm_in),
    .value (value),
    .valid (valid),
    .err   (err),
    .idle  (idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: synchronized-signal history, arming flag and time of the last accepted rise.
  int          cyc = 0;
  bit          s_hist [0:16383];
  bit          sq     [SYNC];
  bit          p_m;
  bit          armed;
  int          last_rise;
  logic [DW-1:0] exp_value = '0;
  bit          exp_valid = 1'b0, exp_err = 1'b0, exp_idle = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) sq[i] = 1'b0;
    p_m = 1'b0; armed = 1'b0; last_rise = 0;
    exp_value = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_idle = 1'b1;
  endtask

  // Predict what the DUT registers on the next clock edge given the inputs just driven.
  task automatic model_step(input bit pwm, input bit e);
    bit s, rise, ev;
    int per, hi;
    s = sq[SYNC-1];
    rise = s && !p_m;
    ev = 1'b0;
    exp_valid = 1'b0;
    if (!armed) begin
      if (rise && e) begin armed = 1'b1; last_rise = cyc; end
    end else if (!e) begin
      armed = 1'b0;
    end else if (rise) begin
      per = cyc - last_rise;
      hi = 0;
      for (int i = last_rise; i < cyc; i++) hi += int'(s_hist[i]);
      if (per == NOM && hi < NOM) begin exp_value = DW'(hi); exp_valid = 1'b1; end
      else ev = 1'b1;
      last_rise = cyc;
    end else if (cyc - last_rise == TMO) begin
      if (s) ev = 1'b1;
      else begin exp_value = '0; exp_valid = 1'b1; end
      armed = 1'b0;
    end
`ifdef PWM_CAP_STICKY_ERR_EN
    exp_err = e ? (exp_err | ev) : 1'b0;
`else
    exp_err = ev;
`endif
    exp_idle = !armed;
    s_hist[cyc] = s;
    p_m = s;
    for (int i = SYNC - 1; i > 0; i--) sq[i] = sq[i-1];
    sq[0] = pwm;
    cyc++;
  endtask

  task automatic step(input bit pwm, input bit e);
    @(negedge clk);
    chk("valid", 32'(valid), 32'(exp_valid));
    chk("value", 32'(value), 32'(exp_value));
    chk("err",   32'(err),   32'(exp_err));
    chk("idle",  32'(idle),  32'(exp_idle));
    pwm_in = pwm;
    en     = e;
    model_step(pwm, e);
  endtask

  task automatic run_period(input int per, input int hi, input int drop_at = -1);
    for (int i = 0; i < per; i++)
      step(i < hi, !(drop_at >= 0 && i >= drop_at && i < drop_at + 3));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pwm_in = 1'b0;
    #1;
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_idle",  32'(idle),  32'd1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Nominal value 5
    for (int k = 0; k < 8; k++) run_period(NOM, 5);
    chk("v5_value", 32'(value), 32'd5);
    chk("v5_err", 32'(err), 32'd0);

    // Extremes, then a low hold that times out as duty 0
    for (int k = 0; k < 3; k++) run_period(NOM, 1);
    chk("v1_value", 32'(value), 32'd1);
    for (int k = 0; k < 3; k++) run_period(NOM, 15);
    chk("v15_value", 32'(value), 32'd15);
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1);
    chk("tmo_value", 32'(value), 32'd0);
    chk("tmo_idle", 32'(idle), 32'd1);

    // Wrong period: value holds
    for (int k = 0; k < 3; k++) run_period(NOM, 7);
    for (int k = 0; k < 4; k++) run_period(12, 4);
    chk("wp_value", 32'(value), 32'd7);
    for (int k = 0; k < 3; k++) run_period(NOM, 7);
    chk("wp_resume", 32'(value), 32'd7);

    // Stuck high
    for (int k = 0; k < 40; k++) step(1'b1, 1'b1);
    chk("stuck_idle", 32'(idle), 32'd1);
    chk("stuck_value", 32'(value), 32'd7);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1);

    // Reset seven cycles into a period-16/high-9 stream
    for (int k = 0; k < 2; k++) run_period(NOM, 9);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1);
    do_reset();
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) run_period(NOM, 9);
    chk("rst_v9", 32'(value), 32'd9);

    // Enable dropped for three cycles mid-stream
    for (int k = 0; k < 3; k++) run_period(NOM, 6);
    run_period(NOM, 6, 8);
    for (int k = 0; k < 3; k++) run_period(NOM, 6);
    chk("en_value", 32'(value), 32'd6);

    // Rise landing on the timeout cycle is measured, not timed out
    for (int k = 0; k < 2; k++) run_period(NOM, 3);
    run_period(TMO, 3);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1);
    chk("coinc_value", 32'(value), 32'd3);
    chk("coinc_idle", 32'(idle), 32'd0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1);
    run_period(NOM, 3);

    // Random mix of good periods, bad periods and enable drops
    for (int k = 0; k < 60; k++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      run_period(int'($urandom_range(10, 20)), int'($urandom_range(1, 9)));
      else if (r == 1) run_period(NOM, int'($urandom_range(1, 15)), int'($urandom_range(0, 12)));
      else             run_period(NOM, int'($urandom_range(1, 15)));
    end
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_capture.md
# pwm_duty_capture

Measures the duty cycle of an incoming PWM waveform and recovers the N-bit value that produced it. It is the receive side of the ALU PWM output: it expects a period of 2^DATA_W clk cycles with high time equal to the encoded value. It emits one `valid` pulse per good period and flags malformed or stuck waveforms. It sits on the FPGA input side, fed from a pin or loopback, and drives readback and display logic.

## Interface
- `DATA_W`, default 4: recovered value width; the expected period is 2^DATA_W cycles.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on `pwm_in`; must be ≥ 2.
- `TIMEOUT`, default 2*2^DATA_W: cycles without a rising edge before a stuck condition is declared; must be > 2^DATA_W.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  capture enable; when low, the block is held idle.
- `pwm_in`  in  1  asynchronous PWM input.
- `value`  out  DATA_W  last recovered duty value; holds between updates.
- `valid`  out  1  one-cycle pulse when `value` is updated.
- `err`  out  1  malformed period or stuck-high indication (see Configuration).
- `idle`  out  1  high while no measurement is in progress.

## Operation
- **Synchronizer:** `pwm_in` passes through SYNC_STAGES flops to give `s`. A registered copy `p` is kept. Rising edge is `rise = s & ~p`.
- **Counters:** `per_cnt` and `hi_cnt` are each clog2(TIMEOUT+1) bits wide.
  - Both saturate at TIMEOUT.
  - On `rise`, both load 1.
  - On every other cycle in MEASURE, `per_cnt` increments, and `hi_cnt` increments when `s` = 1.
- **FSM, IDLE:** `idle` = 1 and the counters are frozen. On `rise` with `en` = 1, go to MEASURE and load the counters. The first edge produces no output.
- **FSM, MEASURE, on `rise`:**
  - If `per_cnt` == 2^DATA_W and `hi_cnt` < 2^DATA_W: `value` ← `hi_cnt[DATA_W-1:0]` and pulse `valid`.
  - Otherwise, pulse `err` and leave `value` unchanged.
  - Counters reload to 1 in either case, and the FSM stays in MEASURE.
- **FSM, MEASURE, on timeout:** when `per_cnt` reaches TIMEOUT with no `rise`:
  - If `s` = 0, treat it as duty 0: `value` ← 0 and pulse `valid`.
  - If `s` = 1, it is stuck high: raise `err`.
  - Then go to IDLE. No repeat reports occur while stuck.
- **Enable:** `en` = 0 forces IDLE the next cycle and suppresses `valid`/`err`. `value` holds. The synchronizer keeps running.
- **Simultaneous events:**
  - `rise` in the same cycle as the timeout threshold: `rise` wins.
  - `rise` in the same cycle as `en` falling: `en` wins, and nothing is reported.

## Timing
- **Reset values:** `value` = 0, `valid` = 0, `err` = 0, `idle` = 1, FSM = IDLE, synchronizer flops = 0, counters = 0.
- `rst` asserted mid-period aborts the measurement at once. After release, the first edge only arms the block.
- **Latency:** `valid`/`err` are registered and assert one cycle after the `rise` cycle. From the first clk edge that samples `pwm_in` high, that is SYNC_STAGES+1 clk edges.
- **Throughput:** one report per period. At the nominal period that is one `valid` every 16 cycles with DATA_W = 4.
- `idle` is registered and falls the cycle after the arming `rise`.
- Input pulses of 1 cycle, i.e. value 1, must be captured. No glitch filtering is applied.

## Configuration
- `PWM_CAP_STICKY_ERR_EN` defined: `err` is a level.
  - It sets on the first error and holds until `rst`, or until `en` is low for at least one cycle.
  - A later `valid` does not clear it.
- Not defined: `err` is a one-cycle pulse per error event, with the same timing as `valid`.

## Test plan
All scenarios use DATA_W = 4, SYNC_STAGES = 2, TIMEOUT = 32, and the macro undefined unless stated.
- **Value 5:** period 16, high 5, repeated. The first edge arms only. On each later edge, `valid` pulses with `value` = 5, exactly 16 cycles apart; `err` stays 0.
- **Extremes:** period 16 with high 1, then high 15 → `value` = 1, then 15. Then hold `pwm_in` low → 32 cycles after the last `rise`, `valid` pulses with `value` = 0 and `idle` = 1. No further pulses follow.
- **Wrong period:** period 12, high 4 → `err` pulse on each edge, no `valid`, `value` holds the previous value. Repeat with the macro defined → `err` stays high after a return to period 16, while `valid` pulses resume.
- **Stuck high:** after arming, hold `pwm_in` high → at the timeout, `err` is asserted and `idle` = 1. There is no `valid`, and nothing further until a new rising edge re-arms the block.
- **Reset mid-period:** `rst` pulsed 7 cycles into a period-16/high-9 stream → all outputs return to reset values immediately. After release, the first edge gives no `valid`, and the second gives `value` = 9.
- **Enable and simultaneous events:**
  - Drop `en` for 3 cycles mid-stream → no reports, `idle` = 1. After `en` returns, the first edge arms and the next one reports.
  - `rise` arriving on the timeout cycle → it is measured as a period rather than reported as a timeout.
